// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, LSU) for a single memory port that
// allows one outstanding transaction. Define MEM_ARB_RR_EN for round-robin grant.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_a,
    input  logic        if_req_we,
    input  logic [3:0]  if_req_be,
    input  logic [31:0] if_req_d,

    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [31:0] if_resp_data,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_req_a,
    input  logic        lsu_req_we,
    input  logic [3:0]  lsu_req_be,
    input  logic [31:0] lsu_req_d,

    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_resp_data,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_a,
    output logic        mem_req_we,
    output logic [3:0]  mem_req_be,
    output logic [31:0] mem_req_d,

    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_resp_data,

    output logic        busy,
    output logic        owner
);

    typedef enum logic {StIdle, StWait} state_t;

    state_t state_q;
    logic   drop_q;
    logic   lock_q;
    logic   lock_grant_q;
    logic   grant_arb;
    logic   grant;
    logic   req_fire;
    logic   resp_fire;

    // Fetch write-enable and byte-enables are overridden downstream.
    logic unused_if_fields;
    assign unused_if_fields = ^{if_req_we, if_req_be};

`ifdef MEM_ARB_RR_EN
    logic last_q;

    // On contention the requester that did not win last time gets the port.
    assign grant_arb = (lsu_req_valid && if_req_valid) ? ~last_q : lsu_req_valid;
`else
    assign grant_arb = lsu_req_valid;
`endif

    // Hold a stalled offer on the same requester until it fires or withdraws.
    assign grant = (lock_q && (lock_grant_q ? lsu_req_valid : if_req_valid)) ?
                   lock_grant_q : grant_arb;

    always_comb begin
        mem_req_valid  = 1'b0;
        if_req_ready   = 1'b0;
        lsu_req_ready  = 1'b0;
        if_resp_valid  = 1'b0;
        lsu_resp_valid = 1'b0;
        mem_resp_ready = 1'b0;

        if (grant) begin
            mem_req_a  = lsu_req_a;
            mem_req_we = lsu_req_we;
            mem_req_be = lsu_req_be;
            mem_req_d  = lsu_req_d;
        end else begin
            mem_req_a  = if_req_a;
            mem_req_we = 1'b0;
            mem_req_be = 4'b1111;
            mem_req_d  = if_req_d;
        end

        if (state_q == StIdle) begin
            mem_req_valid = grant ? lsu_req_valid : if_req_valid;
            if (grant) begin
                lsu_req_ready = mem_req_ready;
            end else begin
                if_req_ready = mem_req_ready;
            end
        end else if (drop_q) begin
            mem_resp_ready = 1'b1;
        end else if (owner) begin
            lsu_resp_valid = mem_resp_valid;
            mem_resp_ready = lsu_resp_ready;
        end else begin
            if_resp_valid  = mem_resp_valid;
            mem_resp_ready = if_resp_ready;
        end
    end

    assign if_resp_data  = mem_resp_data;
    assign lsu_resp_data = mem_resp_data;

    assign req_fire  = mem_req_valid && mem_req_ready;
    assign resp_fire = (state_q == StWait) && mem_resp_valid && mem_resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            busy         <= 1'b0;
            owner        <= 1'b0;
            drop_q       <= 1'b0;
            lock_q       <= 1'b0;
            lock_grant_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        state_q <= StWait;
                        busy    <= 1'b1;
                        owner   <= grant;
                        drop_q  <= 1'b0;
                        lock_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
                        last_q  <= grant;
`endif
                    end else begin
                        lock_q       <= mem_req_valid;
                        lock_grant_q <= grant;
                    end
                end
                StWait: begin
                    // Stores must complete, so only a fetch response is killed.
                    if (flush && !owner) begin
                        drop_q <= 1'b1;
                    end
                    if (resp_fire) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        drop_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_req_valid, if_req_ready, if_req_we;
    logic [31:0] if_req_a, if_req_d;
    logic [3:0]  if_req_be;
    logic        if_resp_valid, if_resp_ready;
    logic [31:0] if_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_we;
    logic [31:0] lsu_req_a, lsu_req_d;
    logic [3:0]  lsu_req_be;
    logic        lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_resp_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_a, mem_req_d;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_data;
    logic        busy, owner;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_req_a       (if_req_a),
        .if_req_we      (if_req_we),
        .if_req_be      (if_req_be),
        .if_req_d       (if_req_d),
        .if_resp_valid  (if_resp_valid),
        .if_resp_ready  (if_resp_ready),
        .if_resp_data   (if_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_a      (lsu_req_a),
        .lsu_req_we     (lsu_req_we),
        .lsu_req_be     (lsu_req_be),
        .lsu_req_d      (lsu_req_d),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_resp_data  (lsu_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_a      (mem_req_a),
        .mem_req_we     (mem_req_we),
        .mem_req_be     (mem_req_be),
        .mem_req_d      (mem_req_d),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy),
        .owner          (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_owner;

        rst = 1'b1; flush = 1'b0;
        if_req_valid = 1'b0; if_req_a = '0; if_req_we = 1'b0; if_req_be = '0; if_req_d = '0;
        lsu_req_valid = 1'b0; lsu_req_a = '0; lsu_req_we = 1'b0; lsu_req_be = '0;
        lsu_req_d = '0;
        if_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        step();
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_resp_ready", mem_resp_ready, 0);
        rst = 1'b0;
        step();

        // Single fetch; a response offered in the fire cycle must be ignored.
        if_req_valid = 1'b1; if_req_a = 32'h100; if_req_we = 1'b1; if_req_be = 4'b0001;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
        if_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
        #1;
        check("f1_mem_req_valid", mem_req_valid, 1);
        check("f1_mem_req_a", mem_req_a, 32'h100);
        check("f1_we_forced", mem_req_we, 0);
        check("f1_be_forced", mem_req_be, 4'hF);
        check("f1_if_req_ready", if_req_ready, 1);
        check("f1_lsu_req_ready", lsu_req_ready, 0);
        check("f1_idle_resp_ready", mem_resp_ready, 0);
        check("f1_idle_if_resp_valid", if_resp_valid, 0);
        check("f1_busy_before", busy, 0);
        step();
        if_req_valid = 1'b0;
        #1;
        check("f1_busy", busy, 1);
        check("f1_owner", owner, 0);
        check("f1_wait_req_valid", mem_req_valid, 0);
        check("f1_if_resp_valid", if_resp_valid, 1);
        check("f1_if_resp_data", if_resp_data, 32'hDEADBEEF);
        check("f1_lsu_resp_valid", lsu_resp_valid, 0);
        check("f1_mem_resp_ready", mem_resp_ready, 1);
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("f1_busy_after", busy, 0);

        // Simultaneous requests: LSU first, store survives a flush.
        lsu_req_valid = 1'b1; lsu_req_a = 32'h200; lsu_req_we = 1'b1; lsu_req_be = 4'b0011;
        lsu_req_d = 32'h1234;
        if_req_valid = 1'b1; if_req_a = 32'h300; if_req_we = 1'b0; if_req_be = 4'b0010;
        #1;
        check("sim_mem_req_a", mem_req_a, 32'h200);
        check("sim_mem_req_we", mem_req_we, 1);
        check("sim_mem_req_be", mem_req_be, 4'b0011);
        check("sim_mem_req_d", mem_req_d, 32'h1234);
        check("sim_lsu_req_ready", lsu_req_ready, 1);
        check("sim_if_req_ready", if_req_ready, 0);
        step();
        lsu_req_valid = 1'b0; flush = 1'b1;
        #1;
        check("sim_owner_lsu", owner, 1);
        check("sim_busy", busy, 1);
        check("sim_wait_if_ready", if_req_ready, 0);
        step();
        flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D;
        #1;
        check("st_lsu_resp_valid", lsu_resp_valid, 1);
        check("st_lsu_resp_data", lsu_resp_data, 32'hCAFEF00D);
        check("st_if_resp_valid", if_resp_valid, 0);
        check("st_mem_resp_ready", mem_resp_ready, 1);
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("sim_fetch_next_busy", busy, 0);
        check("sim_fetch_next_valid", mem_req_valid, 1);
        check("sim_fetch_next_a", mem_req_a, 32'h300);
        check("sim_fetch_next_be", mem_req_be, 4'hF);
        check("sim_fetch_next_ready", if_req_ready, 1);

        // Flush while a fetch is outstanding discards its response.
        step();
        if_req_valid = 1'b0; flush = 1'b1; if_resp_ready = 1'b0;
        #1;
        check("fl_owner", owner, 0);
        check("fl_busy", busy, 1);
        step();
        flush = 1'b0;
        #1;
        check("fl_busy_held", busy, 1);
        check("fl_drop_ready", mem_resp_ready, 1);
        step();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h11111111;
        #1;
        check("fl_if_resp_valid", if_resp_valid, 0);
        check("fl_lsu_resp_valid", lsu_resp_valid, 0);
        check("fl_mem_resp_ready", mem_resp_ready, 1);
        step();
        mem_resp_valid = 1'b0; if_resp_ready = 1'b1;
        #1;
        check("fl_idle", busy, 0);

        // Both continuously valid for four transactions.
        lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_be = 4'hF;
        if_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_owner = (i % 2 == 0) ? 1'b1 : 1'b0;
`else
            exp_owner = 1'b1;
`endif
            #1;
            check($sformatf("arb%0d_a", i), mem_req_a, exp_owner ? 32'h200 : 32'h300);
            step();
            check($sformatf("arb%0d_owner", i), owner, {31'b0, exp_owner});
            mem_resp_valid = 1'b1;
            #1;
            check($sformatf("arb%0d_resp_ready", i), mem_resp_ready, 1);
            step();
            mem_resp_valid = 1'b0;
        end
        lsu_req_valid = 1'b0; if_req_valid = 1'b0;
        step();

        // Stalled fetch offer keeps the grant when the LSU shows up.
        mem_req_ready = 1'b0; if_req_valid = 1'b1; if_req_a = 32'h400;
        #1;
        check("bp_valid", mem_req_valid, 1);
        check("bp_a0", mem_req_a, 32'h400);
        check("bp_if_ready0", if_req_ready, 0);
        step();
        lsu_req_valid = 1'b1;
        #1;
        check("bp_a1", mem_req_a, 32'h400);
        check("bp_lsu_ready1", lsu_req_ready, 0);
        step();
        check("bp_a2", mem_req_a, 32'h400);
        mem_req_ready = 1'b1;
        #1;
        check("bp_if_ready3", if_req_ready, 1);
        check("bp_lsu_ready3", lsu_req_ready, 0);
        step();
        if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #1;
        check("bp_busy", busy, 1);
        check("bp_owner", owner, 0);
        rst = 1'b1; mem_resp_valid = 1'b1;
        #1;
        check("rs_busy", busy, 0);
        check("rs_mem_req_valid", mem_req_valid, 0);
        check("rs_mem_resp_ready", mem_resp_ready, 0);
        check("rs_if_resp_valid", if_resp_valid, 0);
        step();
        rst = 1'b0;
        step();
        check("rs_late_resp_ready", mem_resp_ready, 0);
        check("rs_busy_after", busy, 0);
        mem_resp_valid = 1'b0;
        lsu_req_valid = 1'b1; if_req_valid = 1'b1;
        #1;
        check("rs_rr_lsu_first", mem_req_a, 32'h200);
        lsu_req_valid = 1'b0; if_req_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
